jk_cmd_scheduler: RTL
=====================

Name: jk_cmd_scheduler

Overview:
Shared-resource controller for a bank of JK flip-flops. Up to NUM_REQ requesters issue {hold, reset, set, toggle} commands with a per-bit mask. A round-robin arbiter serialises the commands and drives each command's j/k onto the bank for exactly one clock. The bank state is exported as q/q_ for downstream lab datapaths.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 4, number of JK flip-flops in the bank
IDW, 2, width of grant_id (must be >= clog2(NUM_REQ))

Ports:
clk  input  1  system clock, rising-edge
reset_n  input  1  synchronous active-low reset
req_valid  input  NUM_REQ  per-requester command valid
req_op  input  2*NUM_REQ  per-requester op {j,k}; requester i at [2i+1:2i]
req_mask  input  WIDTH*NUM_REQ  per-requester bit mask; requester i at [WIDTH*i +: WIDTH]
req_ready  output  NUM_REQ  one-hot completion pulse
q  output  WIDTH  bank true outputs
q_  output  WIDTH  bank complement outputs, always ~q
busy  output  1  high when the state is not IDLE
grant_id  output  IDW  index of the current or last granted requester

Behaviour:
- Reset (reset_n sampled low at a rising clk edge):
  - State: IDLE; RR pointer: 0.
  - Outputs: q=0, q_=all 1s, req_ready=0, busy=0, grant_id=0.
  - Latched op/mask/id cleared.
  - Reset mid-operation aborts the command: no bank update, no ready pulse.
- Op encoding {j,k}: 00 hold, 01 reset (q=0), 10 set (q=1), 11 toggle.
- Masking: masked-off bits get j=k=0 and hold their value.
- State machine, states IDLE, APPLY, DONE:
  - IDLE: if any req_valid, select winner from RR pointer upward with wrap. Latch op, mask and id; grant_id<=id; go to APPLY. Otherwise stay in IDLE.
  - APPLY: drive bank j/k from the latched op and mask for this single cycle. The bank updates at the closing edge. Go to DONE.
  - DONE: req_ready[grant_id]=1 for this one cycle. RR pointer<=(grant_id+1) mod NUM_REQ. Go to IDLE.
- Latency and throughput:
  - Valid sampled at edge t0 → q updates at edge t1 → req_ready high during cycle t1..t2.
  - Throughput: one command per 3 cycles.
- Handshake:
  - The requester holds valid, op and mask stable until it sees ready.
  - Payload is latched at t0, so changes after t0 do not affect the command in flight.
  - Valid dropped after t0: the command still completes and the ready pulse still occurs.
  - Valid still high in the cycle after ready is a new request, re-arbitrated in IDLE.
- Boundary conditions:
  - Zero mask: a full 3-cycle transaction with no bit change; ready is still issued.
  - Non-granted requesters are not blocked from asserting; they simply wait.
  - No input is sampled except at rising edges, so sub-cycle glitches on req_* between edges have no effect.
- q_ is combinational ~q and must never equal q.

Optional Feature:
Macro JK_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. The RR pointer is removed or held at 0, and grant order ignores history.
- Undefined (default): round-robin as described in Behaviour.
- All other timing is identical in both builds.

Decomposition:
- Package jk_sched_pkg:
  - Op constants OP_HOLD=2'b00, OP_RESET=2'b01, OP_SET=2'b10, OP_TOGGLE=2'b11.
  - State encodings S_IDLE, S_APPLY, S_DONE.
- Sub-module jk_ff_bank:
  - Parameter WIDTH; ports clk, reset_n, j[WIDTH], k[WIDTH], q, q_.
  - One JK FF per bit with synchronous active-low reset to 0.
  - Instantiated once in jk_cmd_scheduler.
- The arbiter stays inline in the top module.

Test Plan (NUM_REQ=4, WIDTH=4):
1. Reset: hold reset_n=0 for 2 edges → q=4'b0000, q_=4'b1111, req_ready=0, busy=0, grant_id=0. Release, then idle 5 cycles → q unchanged.
2. Single request: req2 op SET, mask 4'b0101, valid at edge t0 → busy at t0, q=4'b0101 at t1, req_ready=4'b0100 for one cycle, grant_id=2.
3. Op sweep on req0 starting from q=4'b0101:
   - TOGGLE mask 4'b1111 → 4'b1010
   - RESET mask 4'b1000 → 4'b0010
   - HOLD mask 4'b1111 → 4'b0010
   - SET mask 4'b0000 → 4'b0010, with the ready pulse still issued
4. Fairness: all four valid continuously with SET masks 0001, 0010, 0100, 1000 after reset.
   - Default build: grants 0,1,2,3,0 at 3-cycle spacing, and q reaches 4'b1111 after 4 commands.
   - With JK_SCHED_FIXED_PRIO_EN: grants 0,0,0…
5. Reset mid-APPLY: req1 TOGGLE mask 4'b1111 with reset_n=0 at the APPLY-closing edge → q=4'b0000, no req_ready pulse. After release with req1 still valid, the command re-runs and q=4'b1111.
6. Glitch immunity: req3 valid/op SET pulsed 1 ns wide mid-cycle, away from any rising edge → q, busy and req_ready unchanged.

Source files
------------

// File: rtl/jk_sched_pkg.sv
// Shared definitions for the JK command scheduler: op codes, FSM states and
// the JK next-state function used by the flip-flop bank.
package jk_sched_pkg;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_APPLY = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  // Characteristic equation Q+ = J&~Q | ~K&Q, applied bitwise.
  function automatic logic [31:0] jk_next(input logic [31:0] q_cur,
                                          input logic [31:0] j_in,
                                          input logic [31:0] k_in);
    return (j_in & ~q_cur) | (~k_in & q_cur);
  endfunction

endpackage

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH JK flip-flops with synchronous active-low reset to 0;
// q_ is always the complement of q.
module jk_ff_bank
  import jk_sched_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_
);

  logic [WIDTH-1:0] r_q;

  // Flip-flop state, one JK FF per bit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_q <= '0;
    end else begin
      r_q <= WIDTH'(jk_next(32'(r_q), 32'(j), 32'(k)));
    end
  end

  assign q  = r_q;
  assign q_ = ~r_q;

endmodule

// File: rtl/jk_cmd_scheduler.sv
// Round-robin scheduler serialising masked JK commands onto a shared FF bank.
// Define JK_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins arbitration.
module jk_cmd_scheduler
  import jk_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int IDW     = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_mask,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH-1:0]         q_,
  output logic                     busy,
  output logic [IDW-1:0]           grant_id
);

  state_t             r_state;
  state_t             w_next;
  logic [IDW-1:0]     r_id;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_mask;
  logic [NUM_REQ-1:0] r_ready;
  logic               r_busy;

  logic [IDW-1:0]     w_ptr_base;
  logic [IDW:0]       w_sum;
  logic [IDW-1:0]     w_cand;
  logic [IDW-1:0]     w_win;
  logic               w_any;
  logic [1:0]         w_sel_op;
  logic [WIDTH-1:0]   w_sel_mask;
  logic [NUM_REQ-1:0] w_ready_next;
  logic [WIDTH-1:0]   w_j;
  logic [WIDTH-1:0]   w_k;

`ifdef JK_SCHED_FIXED_PRIO_EN
  assign w_ptr_base = '0;
`else
  logic [IDW-1:0] r_ptr;

  // Round-robin pointer advances past the requester just served.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (r_state == S_DONE) begin
      r_ptr <= (r_id == IDW'(NUM_REQ - 1)) ? '0 : r_id + IDW'(1);
    end
  end

  assign w_ptr_base = r_ptr;
`endif

  // Winner search: scanning offsets high-to-low lets the lowest offset win.
  always_comb begin
    w_any      = 1'b0;
    w_win      = '0;
    w_sum      = '0;
    w_cand     = '0;
    w_sel_op   = OP_HOLD;
    w_sel_mask = '0;
    for (int o = NUM_REQ - 1; o >= 0; o--) begin
      w_sum  = {1'b0, w_ptr_base} + (IDW+1)'(o);
      w_cand = (w_sum >= (IDW+1)'(NUM_REQ)) ? IDW'(w_sum - (IDW+1)'(NUM_REQ))
                                             : IDW'(w_sum);
      w_any  = w_any | req_valid[w_cand];
      w_win  = req_valid[w_cand] ? w_cand : w_win;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sel_op   = (w_win == IDW'(i)) ? req_op[2*i +: 2] : w_sel_op;
      w_sel_mask = (w_win == IDW'(i)) ? req_mask[WIDTH*i +: WIDTH] : w_sel_mask;
    end
  end

  // Next-state and next ready pulse.
  always_comb begin
    w_next       = r_state;
    w_ready_next = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_next = S_APPLY;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_APPLY: begin
        w_next       = S_DONE;
        w_ready_next = NUM_REQ'(1) << r_id;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, registered outputs and latched command payload.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_id    <= '0;
      r_op    <= OP_HOLD;
      r_mask  <= '0;
      r_ready <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= w_ready_next;
      r_busy  <= (w_next != S_IDLE);
      if (r_state == S_IDLE && w_any) begin
        r_id   <= w_win;
        r_op   <= w_sel_op;
        r_mask <= w_sel_mask;
      end
    end
  end

  // Bank drive is non-zero only during APPLY; masked-off bits hold.
  always_comb begin
    w_j = '0;
    w_k = '0;
    if (r_state == S_APPLY) begin
      case (r_op)
        OP_HOLD:   begin w_j = '0;     w_k = '0;     end
        OP_RESET:  begin w_j = '0;     w_k = r_mask; end
        OP_SET:    begin w_j = r_mask; w_k = '0;     end
        OP_TOGGLE: begin w_j = r_mask; w_k = r_mask; end
        default:   begin w_j = '0;     w_k = '0;     end
      endcase
    end else begin
      w_j = '0;
      w_k = '0;
    end
  end

  jk_ff_bank #(.WIDTH(WIDTH)) u_bank (
    .clk     (clk),
    .reset_n (reset_n),
    .j       (w_j),
    .k       (w_k),
    .q       (q),
    .q_      (q_)
  );

  assign req_ready = r_ready;
  assign busy      = r_busy;
  assign grant_id  = r_id;

endmodule
